// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin sharing of one AXI read port between two masters, one burst per grant.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH         = 32,
  parameter int READ_CHANNEL_WIDTH = 32,
  parameter int READ_BURST_LEN     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m0_ARVALID,
  output logic                          m0_ARREADY,
  input  logic [ADDR_WIDTH-1:0]         m0_ARADDR,
  input  logic [READ_BURST_LEN-1:0]     m0_ARLEN,
  input  logic [2:0]                    m0_ARSIZE,
  input  logic [1:0]                    m0_ARBURST,
  output logic                          m0_RVALID,
  input  logic                          m0_RREADY,
  output logic [READ_CHANNEL_WIDTH-1:0] m0_RDATA,
  output logic                          m0_RLAST,
  output logic [1:0]                    m0_RRESP,
  input  logic                          m1_ARVALID,
  output logic                          m1_ARREADY,
  input  logic [ADDR_WIDTH-1:0]         m1_ARADDR,
  input  logic [READ_BURST_LEN-1:0]     m1_ARLEN,
  input  logic [2:0]                    m1_ARSIZE,
  input  logic [1:0]                    m1_ARBURST,
  output logic                          m1_RVALID,
  input  logic                          m1_RREADY,
  output logic [READ_CHANNEL_WIDTH-1:0] m1_RDATA,
  output logic                          m1_RLAST,
  output logic [1:0]                    m1_RRESP,
  output logic                          s_ARVALID,
  input  logic                          s_ARREADY,
  output logic [ADDR_WIDTH-1:0]         s_ARADDR,
  output logic [READ_BURST_LEN-1:0]     s_ARLEN,
  output logic [2:0]                    s_ARSIZE,
  output logic [1:0]                    s_ARBURST,
  input  logic                          s_RVALID,
  output logic                          s_RREADY,
  input  logic [READ_CHANNEL_WIDTH-1:0] s_RDATA,
  input  logic                          s_RLAST,
  input  logic [1:0]                    s_RRESP,
  output logic [1:0]                    grant,
  output logic                          protocol_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t                    state_q, state_d;
  logic                      owner_q, owner_d, last_q, last_d, err_q;
  logic [READ_BURST_LEN-1:0] len_q, beat_q;
  logic                      in_addr, in_data, ar_hs, r_hs;
  assign in_addr    = state_q == ADDR;
  assign in_data    = state_q == DATA;
  assign s_ARVALID  = in_addr & (owner_q ? m1_ARVALID : m0_ARVALID);
  assign s_ARADDR   = owner_q ? m1_ARADDR : m0_ARADDR;
  assign s_ARLEN    = owner_q ? m1_ARLEN : m0_ARLEN;
  assign s_ARSIZE   = owner_q ? m1_ARSIZE : m0_ARSIZE;
  assign s_ARBURST  = owner_q ? m1_ARBURST : m0_ARBURST;
  assign m0_ARREADY = in_addr & ~owner_q & s_ARREADY;
  assign m1_ARREADY = in_addr & owner_q & s_ARREADY;
  assign s_RREADY   = in_data & (owner_q ? m1_RREADY : m0_RREADY);
  assign m0_RVALID  = in_data & ~owner_q & s_RVALID;
  assign m1_RVALID  = in_data & owner_q & s_RVALID;
  assign m0_RDATA   = s_RDATA;
  assign m1_RDATA   = s_RDATA;
  assign m0_RLAST   = s_RLAST;
  assign m1_RLAST   = s_RLAST;
  assign m0_RRESP   = s_RRESP;
  assign m1_RRESP   = s_RRESP;
  assign grant      = {(state_q != IDLE) & owner_q, (state_q != IDLE) & ~owner_q};
  assign protocol_err = err_q;
  assign ar_hs      = s_ARVALID & s_ARREADY;
  assign r_hs       = s_RVALID & s_RREADY;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (m0_ARVALID | m1_ARVALID) begin
        owner_d = (m0_ARVALID & m1_ARVALID) ? ~last_q : m1_ARVALID;
        state_d = ADDR;
      end
      ADDR: if (ar_hs) state_d = DATA;
      DATA: if (r_hs & s_RLAST) begin
        state_d = IDLE;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // A length error is RLAST disagreeing with the beat counter reaching the latched ARLEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      len_q   <= ar_hs ? s_ARLEN : len_q;
      beat_q  <= ar_hs ? '0 : r_hs ? beat_q + 1'b1 : beat_q;
      err_q   <= err_q | (r_hs & (s_RLAST != (beat_q == len_q)));
    end
  end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed checks of arbitration, routing, gaps and the length check.
module tb_axi_read_arbiter;
  logic        clk = 0, rst = 1;
  logic        m0_ARVALID = 0, m0_ARREADY, m0_RVALID, m0_RREADY = 0, m0_RLAST;
  logic [31:0] m0_ARADDR = 0, m0_RDATA;
  logic [7:0]  m0_ARLEN = 0;
  logic [2:0]  m0_ARSIZE = 3'd2;
  logic [1:0]  m0_ARBURST = 2'd1, m0_RRESP;
  logic        m1_ARVALID = 0, m1_ARREADY, m1_RVALID, m1_RREADY = 0, m1_RLAST;
  logic [31:0] m1_ARADDR = 0, m1_RDATA;
  logic [7:0]  m1_ARLEN = 0;
  logic [2:0]  m1_ARSIZE = 3'd2;
  logic [1:0]  m1_ARBURST = 2'd1, m1_RRESP;
  logic        s_ARVALID, s_ARREADY = 1, s_RVALID = 0, s_RREADY, s_RLAST = 0;
  logic [31:0] s_ARADDR, s_RDATA = 0;
  logic [7:0]  s_ARLEN;
  logic [2:0]  s_ARSIZE;
  logic [1:0]  s_ARBURST, s_RRESP = 0, grant;
  logic        protocol_err;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_ARVALID(m0_ARVALID), .m0_ARREADY(m0_ARREADY), .m0_ARADDR(m0_ARADDR), .m0_ARLEN(m0_ARLEN),
    .m0_ARSIZE(m0_ARSIZE), .m0_ARBURST(m0_ARBURST), .m0_RVALID(m0_RVALID), .m0_RREADY(m0_RREADY),
    .m0_RDATA(m0_RDATA), .m0_RLAST(m0_RLAST), .m0_RRESP(m0_RRESP),
    .m1_ARVALID(m1_ARVALID), .m1_ARREADY(m1_ARREADY), .m1_ARADDR(m1_ARADDR), .m1_ARLEN(m1_ARLEN),
    .m1_ARSIZE(m1_ARSIZE), .m1_ARBURST(m1_ARBURST), .m1_RVALID(m1_RVALID), .m1_RREADY(m1_RREADY),
    .m1_RDATA(m1_RDATA), .m1_RLAST(m1_RLAST), .m1_RRESP(m1_RRESP),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN),
    .s_ARSIZE(s_ARSIZE), .s_ARBURST(s_ARBURST), .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .s_RDATA(s_RDATA), .s_RLAST(s_RLAST), .s_RRESP(s_RRESP),
    .grant(grant), .protocol_err(protocol_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string tag);
    #1;
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_s_arvalid"}, s_ARVALID, 0);
    chk({tag, "_s_rready"}, s_RREADY, 0);
    chk({tag, "_arready"}, {m0_ARREADY, m1_ARREADY}, 0);
    chk({tag, "_rvalid"}, {m0_RVALID, m1_RVALID}, 0);
    chk({tag, "_err"}, protocol_err, 0);
  endtask
  task automatic do_reset;
    rst = 1;
    tick;
    tick;
    rst = 0;
    idle_chk("reset");
  endtask
  // Issue one request from IDLE and serve n beats with RLAST on the last one.
  task automatic do_read(input bit m, input logic [31:0] addr, input logic [7:0] len, input int n);
    int k = 0;
    if (m) begin m1_ARVALID = 1; m1_ARADDR = addr; m1_ARLEN = len; end
    else begin m0_ARVALID = 1; m0_ARADDR = addr; m0_ARLEN = len; end
    #1;
    while (!(m ? m1_ARREADY : m0_ARREADY) && k < 20) begin tick; #1; k++; end
    chk("ar_latency", k, 1);
    chk("ar_addr", s_ARADDR, addr);
    chk("ar_len", s_ARLEN, {24'd0, len});
    chk("ar_grant", grant, m ? 2 : 1);
    chk("ar_other_ready", m ? m0_ARREADY : m1_ARREADY, 0);
    tick;
    m0_ARVALID = 0;
    m1_ARVALID = 0;
    for (int i = 0; i < n; i++) begin
      s_RVALID = 1; s_RDATA = addr + i; s_RLAST = (i == n - 1);
      m0_RREADY = 1; m1_RREADY = 1;
      #1;
      chk("r_valid", {m1_RVALID, m0_RVALID}, m ? 2 : 1);
      chk("r_data", m ? m1_RDATA : m0_RDATA, addr + i);
      tick;
    end
    s_RVALID = 0; s_RLAST = 0; m0_RREADY = 0; m1_RREADY = 0;
    #1;
    chk("end_idle", grant, 0);
  endtask
  initial begin
    int delivered;
    do_reset;
    do_read(0, 32'h100, 8'd3, 4);
    chk("single_err", protocol_err, 0);
    do_reset;
    // Both masters request continuously: strict alternation with a one-cycle gap.
    m0_ARVALID = 1; m0_ARLEN = 0; m0_ARADDR = 32'h10;
    m1_ARVALID = 1; m1_ARLEN = 0; m1_ARADDR = 32'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gap_arvalid", s_ARVALID, 0);
      chk("rr_gap_grant", grant, 0);
      tick;
      #1;
      chk("rr_grant", grant, (i % 2) ? 2 : 1);
      chk("rr_s_arvalid", s_ARVALID, 1);
      chk("rr_other_ready", (i % 2) ? m0_ARREADY : m1_ARREADY, 0);
      tick;
      s_RVALID = 1; s_RLAST = 1; m0_RREADY = 1; m1_RREADY = 1;
      #1;
      chk("rr_rvalid", {m1_RVALID, m0_RVALID}, (i % 2) ? 2 : 1);
      tick;
      s_RVALID = 0; s_RLAST = 0;
    end
    m0_ARVALID = 0; m1_ARVALID = 0; m0_RREADY = 0; m1_RREADY = 0;
    tick;
    // m1 requests during an 8-beat m0 burst.
    m0_ARVALID = 1; m0_ARADDR = 32'h400; m0_ARLEN = 7;
    tick;
    tick;
    m0_ARVALID = 0;
    m1_ARVALID = 1; m1_ARADDR = 32'h200; m1_ARLEN = 0;
    for (int i = 0; i < 8; i++) begin
      s_RVALID = 1; s_RDATA = 32'h400 + i; s_RLAST = (i == 7); m0_RREADY = 1;
      #1;
      chk("ovl_m1_arready", m1_ARREADY, 0);
      chk("ovl_rvalid", {m1_RVALID, m0_RVALID}, 1);
      tick;
    end
    s_RVALID = 0; s_RLAST = 0; m0_RREADY = 0;
    #1;
    chk("ovl_gap", s_ARVALID, 0);
    chk("ovl_gap_ready", m1_ARREADY, 0);
    tick;
    #1;
    chk("ovl_m1_grant", grant, 2);
    chk("ovl_m1_arvalid", s_ARVALID, 1);
    chk("ovl_m1_addr", s_ARADDR, 32'h200);
    tick;
    m1_ARVALID = 0;
    s_RVALID = 1; s_RDATA = 32'h55; s_RLAST = 1; m1_RREADY = 1;
    #1;
    chk("ovl_m1_rvalid", {m1_RVALID, m0_RVALID}, 2);
    chk("ovl_m1_rdata", m1_RDATA, 32'h55);
    tick;
    s_RVALID = 0; s_RLAST = 0; m1_RREADY = 0;
    #1;
    chk("ovl_err", protocol_err, 0);
    // Backpressure: m0 stalls beat 2 for two cycles.
    m0_ARVALID = 1; m0_ARADDR = 32'h600; m0_ARLEN = 3;
    tick;
    tick;
    m0_ARVALID = 0;
    delivered = 0;
    for (int c = 0; c < 6; c++) begin
      int b;
      b = delivered;
      s_RVALID = 1; s_RDATA = 32'h600 + b; s_RLAST = (b == 3);
      m0_RREADY = !(c == 2 || c == 3);
      #1;
      if (c == 2 || c == 3) begin
        chk("bp_s_rready", s_RREADY, 0);
        chk("bp_data_stable", m0_RDATA, 32'h602);
        chk("bp_rvalid", m0_RVALID, 1);
      end
      if (m0_RVALID && m0_RREADY) delivered++;
      tick;
    end
    s_RVALID = 0; s_RLAST = 0; m0_RREADY = 0;
    #1;
    chk("bp_beats", delivered, 4);
    chk("bp_idle", grant, 0);
    chk("bp_err", protocol_err, 0);
    // Early RLAST on beat 3 of a 4-beat request.
    do_read(0, 32'h800, 8'd3, 3);
    chk("early_err", protocol_err, 1);
    do_read(1, 32'h900, 8'd1, 2);
    chk("err_sticky", protocol_err, 1);
    // Reset in the middle of a data burst.
    m0_ARVALID = 1; m0_ARADDR = 32'hA00; m0_ARLEN = 3;
    tick;
    tick;
    m0_ARVALID = 0;
    s_RVALID = 1; m0_RREADY = 1;
    #1;
    chk("mid_s_rready", s_RREADY, 1);
    rst = 1;
    tick;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_rready", s_RREADY, 0);
    chk("mid_rst_rvalid", m0_RVALID, 0);
    tick;
    s_RVALID = 0; m0_RREADY = 0;
    rst = 0;
    idle_chk("mid_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-master round-robin arbiter that shares one AXI read port (AR + R channels) of `axi_slave` between the instruction-fetch path (m0) and the data-memory path (m1) of the CPU. It grants one master per burst, keeps that grant until the RLAST beat is handshaken, and routes R beats back only to the owner. It also checks that the burst length returned by the slave matches the requested ARLEN.

## Interface
Parameters:
- ADDR_WIDTH, 32, AR address width
- READ_CHANNEL_WIDTH, 32, RDATA width per beat
- READ_BURST_LEN, 8, ARLEN width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- m0_ARVALID/m1_ARVALID in, s_ARVALID out  1  AR valid
- m0_ARREADY/m1_ARREADY out, s_ARREADY in  1  AR ready
- m0_ARADDR/m1_ARADDR in, s_ARADDR out  ADDR_WIDTH  read address
- m0_ARLEN/m1_ARLEN in, s_ARLEN out  READ_BURST_LEN  beats-1
- m0_ARSIZE/m1_ARSIZE in, s_ARSIZE out  3  beat size
- m0_ARBURST/m1_ARBURST in, s_ARBURST out  2  burst type
- s_RVALID in, m0_RVALID/m1_RVALID out  1  R valid
- s_RREADY out, m0_RREADY/m1_RREADY in  1  R ready
- s_RDATA in, m0_RDATA/m1_RDATA out  READ_CHANNEL_WIDTH  read data
- s_RLAST in, m0_RLAST/m1_RLAST out  1  last beat
- s_RRESP in, m0_RRESP/m1_RRESP out  2  response
- grant  out  2  one-hot current owner; 00 when IDLE
- protocol_err  out  1  sticky burst-length mismatch flag

## Operation
- States: IDLE, ADDR, DATA. The registered state and owner drive all muxing.
- IDLE: if any mK_ARVALID is high, pick the owner by round-robin. Priority goes to the master not served last. Latch owner, go to ADDR. With no request, stay in IDLE.
- ADDR: s_ARVALID = owner's ARVALID. s_AR* fields come combinationally from the owner. Owner's ARREADY = s_ARREADY; the other master's ARREADY = 0. On s_ARVALID&&s_ARREADY, latch ARLEN into len_q, clear beat_cnt, go to DATA.
- DATA: owner's RVALID = s_RVALID; the other master's RVALID = 0. s_RREADY = owner's RREADY. RDATA/RLAST/RRESP go to both masters; only RVALID qualifies them.
  - On each R handshake, beat_cnt increments (READ_BURST_LEN bits).
  - On an R handshake with s_RLAST: go to IDLE and record owner as last served.
- Outside DATA: s_RREADY = 0, all mK_RVALID = 0. Outside ADDR: s_ARVALID = 0, all mK_ARREADY = 0.
- Length check: set protocol_err if either occurs:
  - s_RLAST is handshaken with beat_cnt != len_q;
  - a beat is handshaken with beat_cnt == len_q and s_RLAST low.
- protocol_err is cleared only by rst. The burst still ends only on RLAST.
- ARLEN is passed through unmodified. The arbiter never reorders or splits bursts.
- Requests from the non-owner are ignored until the state returns to IDLE. Masters must hold ARVALID and AR fields until their ARREADY is seen (AXI rule).

## Timing
- Reset (rst high at an edge) puts the state in IDLE. Reset values:
  - grant = 00, protocol_err = 0, beat_cnt = 0, len_q = 0;
  - last served = m1, so m0 wins the first tie;
  - all VALID/READY outputs 0.
- Reset mid-burst: the state returns to IDLE on that edge and outputs drop the same cycle after the edge. The slave is reset together with the arbiter.
- Latency: mK_ARVALID rising in IDLE at cycle N gives s_ARVALID high at N+1. R-channel forwarding is combinational, with zero added latency.
- Back-to-back bursts: RLAST handshake at cycle N gives IDLE at N+1 and s_ARVALID of the next owner at N+2. This leaves a one-cycle minimum gap.
- Simultaneous m0/m1 requests in IDLE: only one is granted. The other's ARREADY stays 0 until its own ADDR state.
- grant is registered and equals the one-hot owner throughout ADDR and DATA.

## Test plan
- Reset: rst held 2 cycles, including once mid-DATA burst. Then: grant=00, s_ARVALID=0, s_RREADY=0, m0/m1 ARREADY and RVALID=0, protocol_err=0.
- Single m0 read, ARADDR=0x100, ARLEN=3, slave ARREADY immediate. Then: s_ARADDR=0x100 one cycle after request, 4 beats reach m0, m1_RVALID=0 throughout, IDLE after RLAST, protocol_err=0.
- m0 and m1 request together after reset, ARLEN=0 each, and repeat twice. Then: grant order 01, 10, 01, 10, with a one-cycle gap between each RLAST and the next s_ARVALID.
- m1 requests during an m0 ARLEN=7 burst. Then: m1_ARREADY=0 for all 8 beats, and m1 is granted with s_ARVALID two cycles after m0's RLAST handshake.
- m0_RREADY held low for 2 cycles at beat 2 while s_RVALID=1. Then: s_RREADY=0 for those cycles, beat 2 data stays stable and is delivered once, and the total is 4 beats.
- Slave asserts RLAST on the third beat of an ARLEN=3 burst. Then: protocol_err=1 sticky, state goes to IDLE, next burst proceeds, protocol_err is still 1 until rst.
